// File: rtl/down_counter_ctrl.sv
// down_counter_ctrl
// Sequencer for a WIDTH-bit down-counter. A start request in IDLE loads a
// value and the count then steps down by one every PRESCALE clocks until it
// reaches zero. The sequencer supports pause (HOLD), abort and auto-reload.
// Terminal count is flagged by a one-cycle done pulse. A per-bit toggle
// enable lets an external JK bank (J=K=toggle_en[i]) follow the count.
//
// Ports
//   clk         : system clock, rising edge
//   rst_n       : synchronous active-low reset
//   start       : load-and-run request, honoured only in IDLE
//   load_val    : start value, captured on the accepting edge
//   auto_reload : captured with start; restart from the captured value after zero
//   pause       : level, freezes count and prescaler while high
//   abort       : return to IDLE from any state, no done pulse
//   busy        : high in RUN and HOLD (registered)
//   done        : one-cycle pulse in the first cycle count reads 0 (registered)
//   count       : current counter value (registered)
//   toggle_en   : count ^ next count in cycles where the count is updated
module down_counter_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    input  logic             pause,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] toggle_en
);

    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] latch_q, latch_d;
    logic             reload_q, reload_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             upd_en;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        latch_d  = latch_q;
        reload_d = reload_q;
        pre_d    = pre_q;
        done_d   = 1'b0;
        upd_en   = 1'b0;

        if (abort) begin
            // Abort wins over everything, including a coincident terminal tick.
            state_d = S_IDLE;
            count_d = '0;
            pre_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        latch_d  = load_val;
                        reload_d = auto_reload;
                        count_d  = load_val;
                        pre_d    = '0;
                        upd_en   = 1'b1;
                        // A zero load completes immediately without running.
                        if (load_val != '0) begin
                            state_d = S_RUN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end

                S_RUN, S_HOLD: begin
                    if (pause) begin
                        // Pause beats a coincident tick: nothing advances.
                        state_d = S_HOLD;
                    end else begin
                        // Leaving HOLD counts as a normal RUN cycle so a pause
                        // of P cycles stretches the run by exactly P cycles.
                        state_d = S_RUN;
                        if (pre_q == PRE_LAST) begin
                            pre_d  = '0;
                            upd_en = 1'b1;
                            if (count_q != '0) begin
                                count_d = count_q - WIDTH'(1);
                                if (count_q == WIDTH'(1)) begin
                                    done_d = 1'b1;
                                    if (!reload_q) begin
                                        state_d = S_IDLE;
                                    end
                                end
                            end else begin
                                // Only reload runs ever sit at zero in RUN.
                                count_d = latch_q;
                            end
                        end else begin
                            pre_d = pre_q + PW'(1);
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                    pre_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            latch_q  <= '0;
            reload_q <= 1'b0;
            pre_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            latch_q  <= latch_d;
            reload_q <= reload_d;
            pre_q    <= pre_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Held at zero during reset so the JK bank is not disturbed while the
    // internal count is being cleared.
    assign toggle_en = (rst_n && upd_en) ? (count_q ^ count_d) : '0;
    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;

endmodule

// File: tb/tb_down_counter_ctrl.sv
module tb_down_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] load_val;
    logic       auto_reload;
    logic       pause;
    logic       abort;

    logic       busy1, done1, busy3, done3;
    logic [3:0] cnt1, tog1, cnt3, tog3;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    down_counter_ctrl #(.WIDTH(4), .PRESCALE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .load_val(load_val),
        .auto_reload(auto_reload), .pause(pause), .abort(abort),
        .busy(busy1), .done(done1), .count(cnt1), .toggle_en(tog1)
    );

    down_counter_ctrl #(.WIDTH(4), .PRESCALE(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start), .load_val(load_val),
        .auto_reload(auto_reload), .pause(pause), .abort(abort),
        .busy(busy3), .done(done3), .count(cnt3), .toggle_en(tog3)
    );

    // Behavioural model: a run is described by its load value, reload mode
    // and the number of un-paused cycles elapsed since it was accepted. The
    // count is derived from elapsed cycles with plain division.
    typedef struct {
        bit act;
        int L;
        bit rl;
        int e;
        bit done;
    } mst_t;

    mst_t ms [2];
    int   PS [2] = '{1, 3};

    function automatic int mcount(mst_t s, int p);
        int k;
        if (!s.act) return 0;
        k = s.e / p;
        if (s.rl) return s.L - (k % (s.L + 1));
        return s.L - k;
    endfunction

    function automatic mst_t mnext(mst_t s, int p, bit rn, bit st, int lv,
                                   bit arl, bit pse, bit abt);
        mst_t n;
        int   k;
        n      = s;
        n.done = 1'b0;
        if (!rn) begin
            n.act = 1'b0; n.L = 0; n.rl = 1'b0; n.e = 0;
        end else if (abt) begin
            n.act = 1'b0;
        end else if (!s.act) begin
            if (st) begin
                n.L  = lv;
                n.rl = arl;
                n.e  = 0;
                if (lv == 0) n.done = 1'b1;
                else         n.act  = 1'b1;
            end
        end else if (!pse) begin
            n.e = s.e + 1;
            if (n.e % p == 0) begin
                k = n.e / p;
                if (s.rl) begin
                    if (k % (s.L + 1) == s.L) n.done = 1'b1;
                end else if (k == s.L) begin
                    n.done = 1'b1;
                    n.act  = 1'b0;
                end
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            ms[i] = mnext(ms[i], PS[i], rst_n, start, int'(load_val),
                          auto_reload, pause, abort);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                mst_t nx;
                int   etog;
                nx   = mnext(ms[i], PS[i], rst_n, start, int'(load_val),
                             auto_reload, pause, abort);
                etog = (rst_n && !abort) ? (mcount(ms[i], PS[i]) ^ mcount(nx, PS[i])) : 0;
                chk($sformatf("model_count[P%0d]", PS[i]), int'(i == 0 ? cnt1 : cnt3), mcount(ms[i], PS[i]));
                chk($sformatf("model_busy[P%0d]", PS[i]), int'(i == 0 ? busy1 : busy3), int'(ms[i].act));
                chk($sformatf("model_done[P%0d]", PS[i]), int'(i == 0 ? done1 : done3), int'(ms[i].done));
                chk($sformatf("model_tog[P%0d]", PS[i]), int'(i == 0 ? tog1 : tog3), etog);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    initial begin
        int tt  [5] = '{1, 7, 1, 3, 1};
        int seq [9] = '{2, 2, 2, 1, 1, 1, 0, 0, 0};

        rst_n = 1'b0; start = 1'b1; load_val = 4'd7;
        auto_reload = 1'b0; pause = 1'b0; abort = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        #1;
        chk("rst_count", int'(cnt1), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_done", int'(done1), 0);
        chk("rst_count_p3", int'(cnt3), 0);
        // start still high: the first edge with rst_n=1 accepts it
        rst_n = 1'b1;
        step();
        #1;
        chk("rst_release_accept", int'(cnt1), 7);
        chk("rst_release_busy", int'(busy1), 1);
        start = 1'b0;
        do_abort();

        // PRESCALE=1, load 5, no reload
        start = 1'b1; load_val = 4'd5; auto_reload = 1'b0;
        #1;
        chk("t1_tog_accept", int'(tog1), 5);
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("t1_count%0d", i), int'(cnt1), 5 - i);
            chk($sformatf("t1_tog%0d", i), int'(tog1), tt[i]);
            chk($sformatf("t1_done%0d", i), int'(done1), 0);
            chk($sformatf("t1_busy%0d", i), int'(busy1), 1);
            step();
        end
        #1;
        chk("t1_count_end", int'(cnt1), 0);
        chk("t1_done_end", int'(done1), 1);
        chk("t1_busy_end", int'(busy1), 0);
        step();
        #1;
        chk("t1_done_once", int'(done1), 0);

        // PRESCALE=3, load 2, auto-reload
        do_abort();
        start = 1'b1; load_val = 4'd2; auto_reload = 1'b1;
        step();
        start = 1'b0; auto_reload = 1'b0;
        for (int c = 0; c < 27; c++) begin
            #1;
            chk($sformatf("t2_count%0d", c), int'(cnt3), seq[c % 9]);
            chk($sformatf("t2_done%0d", c), int'(done3), (c % 9 == 6) ? 1 : 0);
            if (c % 9 == 8) chk($sformatf("t2_reload_tog%0d", c), int'(tog3), 2);
            step();
        end

        // pause for 4 cycles after the first decrement, PRESCALE=1
        do_abort();
        start = 1'b1; load_val = 4'd4;
        step();
        start = 1'b0;
        #1;
        chk("t3_c0", int'(cnt1), 4);
        step();
        pause = 1'b1;
        #1;
        chk("t3_c1", int'(cnt1), 3);
        step();
        for (int j = 0; j < 3; j++) begin
            #1;
            chk($sformatf("t3_hold_count%0d", j), int'(cnt1), 3);
            chk($sformatf("t3_hold_busy%0d", j), int'(busy1), 1);
            step();
        end
        pause = 1'b0;
        #1;
        chk("t3_c5", int'(cnt1), 3);
        step();
        #1;
        chk("t3_c6", int'(cnt1), 2);
        step();
        #1;
        chk("t3_c7", int'(cnt1), 1);
        chk("t3_c7_done", int'(done1), 0);
        step();
        #1;
        chk("t3_c8", int'(cnt1), 0);
        chk("t3_c8_done", int'(done1), 1);
        chk("t3_c8_busy", int'(busy1), 0);

        // abort coincident with the terminal tick, then a zero-load start
        do_abort();
        start = 1'b1; load_val = 4'd2; auto_reload = 1'b0;
        step();
        start = 1'b0;
        #1;
        chk("t4_c0", int'(cnt1), 2);
        step();
        abort = 1'b1;
        #1;
        chk("t4_abort_tog", int'(tog1), 0);
        step();
        abort = 1'b0;
        start = 1'b1; load_val = 4'd0;
        #1;
        chk("t4_abort_count", int'(cnt1), 0);
        chk("t4_abort_done", int'(done1), 0);
        chk("t4_abort_busy", int'(busy1), 0);
        step();
        start = 1'b0;
        #1;
        chk("t4_zero_done", int'(done1), 1);
        chk("t4_zero_busy", int'(busy1), 0);
        step();
        #1;
        chk("t4_zero_done_once", int'(done1), 0);
        chk("t4_zero_busy2", int'(busy1), 0);

        // start while busy is ignored
        start = 1'b1; load_val = 4'd3;
        step();
        load_val = 4'd9;
        #1;
        chk("t5_c0", int'(cnt1), 3);
        step();
        #1;
        chk("t5_c1", int'(cnt1), 2);
        step();
        start = 1'b0;
        #1;
        chk("t5_c2", int'(cnt1), 1);
        step();
        #1;
        chk("t5_c3", int'(cnt1), 0);
        chk("t5_c3_done", int'(done1), 1);
        step();

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n       = ($urandom % 64) != 0;
            abort       = ($urandom % 32) == 0;
            start       = ($urandom % 4) == 0;
            pause       = ($urandom % 5) == 0;
            load_val    = 4'($urandom);
            auto_reload = 1'($urandom);
            step();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
